// File: rtl/pixel_deserializer_if.sv
// Serial pixel link input and reassembled-pixel valid/ready output bundle.
interface pixel_deserializer_if #(
  parameter int PIXEL_WIDTH = 24
);
  logic                   serial_data;
  logic                   serial_valid;
  logic                   sync;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   pixel_valid;
  logic                   pixel_ready;

  modport master (
    output serial_data, serial_valid, sync, pixel_ready,
    input  pixel_data, pixel_valid
  );

  modport slave (
    input  serial_data, serial_valid, sync, pixel_ready,
    output pixel_data, pixel_valid
  );
endinterface

// File: rtl/pixel_deserializer.sv
// Serial pixel link receiver: sync-aligned MSB-first word assembly feeding a
// small output FIFO with a valid/ready handshake.
//
// state | meaning
// HUNT  | waiting for a sync-qualified bit; all other bits ignored
// SHIFT | aligned; assembling words, realigning on unexpected sync
module pixel_deserializer #(
  parameter int PIXEL_WIDTH = 24,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pixel_deserializer_if.slave         bus,
  input  logic                        clear_status,
  output logic                        locked,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  sync_err_count
);

  localparam int SHIFT_W = PIXEL_WIDTH - 1;
  localparam int CNT_W   = $clog2(PIXEL_WIDTH);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIXEL_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [SHIFT_W-1:0]   shift_q, shift_nxt;
  logic [PIXEL_WIDTH-1:0] word;
  logic                 push;
  logic                 realign;

  logic [PIXEL_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic [PIXEL_WIDTH-1:0] last_q;
  logic                 pop, full, wr_en, ovf_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      shift_q <= shift_nxt;
    end
  end

  // Only the low W-1 bits need storing; the arriving bit completes the word.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_nxt = shift_q;
    push      = 1'b0;
    realign   = 1'b0;
    word      = {shift_q, bus.serial_data};
    if (bus.serial_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.sync) begin
            state_nxt = SHIFT;
            shift_nxt = SHIFT_W'(bus.serial_data);
            cnt_nxt   = CNT_W'(1);
          end
        end
        SHIFT: begin
          if (bus.sync && (cnt_q != '0)) begin
            realign   = 1'b1;
            shift_nxt = SHIFT_W'(bus.serial_data);
            cnt_nxt   = CNT_W'(1);
          end else begin
            shift_nxt = word[SHIFT_W-1:0];
            if (cnt_q == LAST_BIT) begin
              push    = 1'b1;
              cnt_nxt = '0;
            end else begin
              cnt_nxt = cnt_q + 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state_q == SHIFT);

  assign bus.pixel_valid = (level_q != '0);
  assign pop     = bus.pixel_valid && bus.pixel_ready;
  assign full    = (level_q == FULL_LVL);
  assign wr_en   = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= word;
  end

  // last_q keeps the most recently popped word visible while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.pixel_data = bus.pixel_valid ? mem[rd_ptr_q] : last_q;
  assign fifo_level     = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow       <= 1'b0;
      sync_err_count <= '0;
    end else begin
      if (ovf_evt)           overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;

      if (realign) begin
        if (sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 1'b1;
      end else if (clear_status) begin
        sync_err_count <= '0;
      end
    end
  end

endmodule

// File: doc/pixel_deserializer.md
Name: pixel_deserializer

Overview:
- Receive end of the serial pixel link. Samples an MSB-first serial bit stream and reassembles PIXEL_WIDTH-bit RGB words.
- Aligns to a per-pixel sync marker and recovers from misalignment.
- Buffers reassembled pixels in a small output FIFO with a valid/ready handshake toward the downstream display-pipeline stage.

Parameters:
- PIXEL_WIDTH, 24, bits per pixel (RGB 8:8:8); min 2.
- FIFO_DEPTH, 4, output FIFO entries; power of two, min 2.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_data  input  1  serial bit, MSB of pixel first.
- serial_valid  input  1  serial_data carries a bit this cycle.
- sync  input  1  qualified by serial_valid; marks this bit as MSB of a new pixel.
- clear_status  input  1  one-cycle pulse; clears overflow and sync_err_count.
- pixel_data  output  PIXEL_WIDTH  FIFO head word.
- pixel_valid  output  1  FIFO non-empty.
- pixel_ready  input  1  downstream accepts head word.
- locked  output  1  high while in SHIFT state.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: a complete pixel was dropped because the FIFO was full.
- sync_err_count  output  8  saturating count of realignments.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = HUNT, bit counter = 0, shift register = 0, FIFO empty.
  - pixel_data = 0, pixel_valid = 0, locked = 0, fifo_level = 0, overflow = 0, sync_err_count = 0.
  - Reset asserted mid-pixel or mid-handshake discards the partial word and all FIFO contents.
- A bit is sampled only on cycles with serial_valid = 1. When serial_valid = 0, the counter and shift register hold; gaps of any length are allowed between bits.
- State HUNT:
  - Bits without sync are ignored.
  - serial_valid && sync: capture the bit as MSB, counter = 1, go to SHIFT.
- State SHIFT:
  - Each sampled bit: shift register <= {shift[PIXEL_WIDTH-2:0], serial_data}, counter + 1.
  - On the sampled bit that makes counter reach PIXEL_WIDTH: push word {shift[PIXEL_WIDTH-2:0], serial_data} into the FIFO on that same edge, then counter = 0. Stay in SHIFT; the next sampled bit is the MSB of the next pixel.
  - sync with counter = 0: normal; no error.
  - sync with counter != 0 (misalignment): discard the partial word, treat this bit as the MSB (counter = 1), increment sync_err_count (saturates at 255). State stays SHIFT.
  - sync on the bit that would complete a word counts as misalignment: no push, realign.
- Latency: pixel_valid rises the cycle after the edge sampling the LSB, when the FIFO was empty. There is no added pipeline stage.
- FIFO:
  - pixel_data = head entry and is stable while pixel_valid && !pixel_ready.
  - Pop on pixel_valid && pixel_ready.
  - Push when full without a same-cycle pop: word dropped, overflow <= 1, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur; no overflow.
  - Push and pop in the same cycle when empty: the push is stored and pixel_valid rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level updates +1/-1/0 accordingly.
  - When empty, pixel_data holds the last value popped (0 after reset).
- clear_status clears overflow and sync_err_count on the next edge. Same-cycle set events win over clear.
- The upstream serializer emits PIXEL_WIDTH valid bits followed by one idle (serial_valid = 0) cycle per pixel. The sustained input rate therefore never exceeds one pixel per PIXEL_WIDTH+1 cycles, and the block must accept back-to-back pixels with no idle cycle as well.

Test Plan:
- Reset, then 24 bits of 0xA5C33C MSB-first with sync on the first bit -> HUNT to SHIFT on the first bit, locked = 1, pixel_valid = 1 one cycle after the 24th bit, pixel_data = 0xA5C33C, fifo_level = 1.
- Stream 0x000001, 0xFFFFFE, 0x800000 back-to-back with pixel_ready = 1 -> three pops in order with exact values; fifo_level returns to 0; overflow = 0.
- pixel_ready = 0 while 5 pixels arrive (DEPTH = 4) -> fifo_level = 4, 5th word dropped, overflow = 1. Draining returns the first 4 words in order. A clear_status pulse -> overflow = 0.
- sync asserted after 10 bits of a pixel, followed by 24 bits of 0x123456 -> sync_err_count = 1 and the single pixel output is 0x123456. Repeat 300 times -> sync_err_count = 255.
- Random serial_valid gaps (0-5 cycles) while sending 0x5A5A5A -> output 0x5A5A5A unaffected; bits before the first sync are ignored in HUNT.
- rst_n pulsed low after 12 bits, with 2 words already in the FIFO -> immediately pixel_valid = 0, fifo_level = 0, locked = 0. The next synced pixel decodes correctly.
